// File: rtl/rr_arbiter_32_if.sv
// Request/grant bundle between the requesters and rr_arbiter_32.
// The master side drives req/done; the slave side is the arbiter.
interface rr_arbiter_32_if;
  logic [31:0] req;
  logic        done;
  logic [31:0] grant;
  logic [4:0]  select;
  logic        busy;
  logic        timeout;

  modport master (
    output req, done,
    input  grant, select, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, select, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter_32.sv
// 32-way round-robin arbiter with a registered one-hot grant and binary select.
// Optional macro RR_ARB_TIMEOUT_EN adds a hold counter that forces release after TIMEOUT cycles.
module rr_arbiter_32 #(
  parameter int TIMEOUT = 16
) (
  input  logic           clock,
  input  logic           reset,
  rr_arbiter_32_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  r_state;
  logic [4:0]  r_ptr;
  logic [31:0] r_grant;
  logic [4:0]  r_select;
  logic        r_busy;

  logic        w_found;
  logic [4:0]  w_idx;
  logic [4:0]  w_cand;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rr_arbiter_32: TIMEOUT must be at least 1");
  end

  // Scan downward so the candidate closest to ptr (smallest offset) wins last.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 31; k >= 0; k--) begin
      w_cand = r_ptr + 5'(k);
      if (bus.req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;
  logic          r_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_select  <= '0;
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state  <= BUSY;
            r_grant  <= 32'(1) << w_idx;
            r_select <= w_idx;
            r_busy   <= 1'b1;
            r_ptr    <= w_idx + 5'd1;
            r_count  <= '0;
          end
        end
        default: begin
          if (bus.done) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (r_count == CW'(TIMEOUT - 1)) begin
            // This cycle is the TIMEOUT-th held cycle; release as if done arrived.
            r_state   <= IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_count   <= r_count + CW'(1);
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.timeout = r_timeout;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_select <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state  <= BUSY;
            r_grant  <= 32'(1) << w_idx;
            r_select <= w_idx;
            r_busy   <= 1'b1;
            r_ptr    <= w_idx + 5'd1;
          end
        end
        default: begin
          if (bus.done) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.timeout = 1'b0;
`endif

  assign bus.grant  = r_grant;
  assign bus.select = r_select;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Self-checking bench for rr_arbiter_32: directed scenarios plus random traffic
// compared against a behavioural round-robin model.
module tb_rr_arbiter_32;

  localparam int TIMEOUT = 16;

  logic clock;
  logic reset;

  rr_arbiter_32_if arbBus ();

  rr_arbiter_32 #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (arbBus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nPassed = 0;

  // Behavioural model state: who holds the grant and where the next search starts.
  int mBusy;
  int mSel;
  int mPtr;
  int mCount;
  int mTimeout;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mBusy = 0; mSel = 0; mPtr = 0; mCount = 0; mTimeout = 0;
  endtask

  task automatic modelStep(input logic [31:0] r, input logic d);
    if (mBusy == 0) begin
      for (int k = 0; k < 32; k++) begin
        int idx;
        idx = (mPtr + k) % 32;
        if (r[idx]) begin
          mBusy = 1; mSel = idx; mPtr = (idx + 1) % 32; mCount = 0;
          break;
        end
      end
    end else if (d) begin
      mBusy = 0;
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      mCount++;
      if (mCount >= TIMEOUT) begin
        mBusy = 0; mTimeout = 1;
      end
`endif
    end
  endtask

  task automatic compareAll(input string tag);
    logic [31:0] expGrant;
    expGrant = (mBusy != 0) ? (32'd1 << mSel) : 32'd0;
    checkOutput({tag, ".grant"}, arbBus.grant, expGrant);
    checkOutput({tag, ".select"}, 32'(arbBus.select), 32'(mSel));
    checkOutput({tag, ".busy"}, 32'(arbBus.busy), 32'(mBusy));
    checkOutput({tag, ".timeout"}, 32'(arbBus.timeout), 32'(mTimeout));
  endtask

  // Drive one cycle of inputs at the falling edge, then check just after the rising edge.
  task automatic applyStimulus(input logic [31:0] r, input logic d, input string tag);
    @(negedge clock);
    arbBus.req  = r;
    arbBus.done = d;
    modelStep(r, d);
    @(posedge clock);
    #1;
    compareAll(tag);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    arbBus.req  = '0;
    arbBus.done = 1'b0;
    modelReset();
    #1;
    compareAll("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    arbBus.req  = '0;
    arbBus.done = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    doReset();

    // Single requester grant and release.
    applyStimulus(32'h0000_0001, 1'b0, "single");
    checkOutput("single.grantConst", arbBus.grant, 32'h0000_0001);
    applyStimulus(32'h0000_0001, 1'b1, "singleDone");
    checkOutput("singleDone.busyConst", 32'(arbBus.busy), 32'd0);

    // All requesting: selects must rotate 0..31,0 with an idle cycle between grants.
    doReset();
    for (int g = 0; g < 33; g++) begin
      applyStimulus(32'hFFFF_FFFF, 1'b0, "rotGrant");
      checkOutput("rotSeq", 32'(arbBus.select), 32'(g % 32));
      applyStimulus(32'hFFFF_FFFF, 1'b1, "rotRelease");
    end

    // Wrap search from ptr=5.
    doReset();
    applyStimulus(32'h0000_0010, 1'b0, "wrapSetup");
    applyStimulus(32'h0000_0000, 1'b1, "wrapSetupDone");
    applyStimulus(32'h0000_0011, 1'b0, "wrapFirst");
    checkOutput("wrapFirst.selConst", 32'(arbBus.select), 32'd0);
    applyStimulus(32'h0000_0011, 1'b1, "wrapFirstDone");
    applyStimulus(32'h0000_0011, 1'b0, "wrapSecond");
    checkOutput("wrapSecond.selConst", 32'(arbBus.select), 32'd4);

    // Holder drops its request: grant must persist until done.
    doReset();
    applyStimulus(32'h0000_0008, 1'b0, "dropGrant");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h0000_0000, 1'b0, "dropHold");
      checkOutput("dropHold.grantConst", arbBus.grant, 32'h0000_0008);
    end
    applyStimulus(32'h0000_0000, 1'b1, "dropDone");

    // Done while idle is ignored.
    applyStimulus(32'h0000_0000, 1'b1, "idleDone");

    // Asynchronous reset mid-grant, then search restarts from index 0.
    doReset();
    applyStimulus(32'h0002_0000, 1'b0, "asyncGrant");
    @(negedge clock);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("asyncRst.grant", arbBus.grant, 32'd0);
    checkOutput("asyncRst.busy", 32'(arbBus.busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(32'h8002_0000, 1'b0, "afterRst");
    checkOutput("afterRst.selConst", 32'(arbBus.select), 32'd17);

    // Holder never signals done.
    doReset();
    applyStimulus(32'h0000_0001, 1'b0, "holdGrant");
    for (int i = 0; i < 100; i++) applyStimulus(32'h0000_0000, 1'b0, "hold");
`ifdef RR_ARB_TIMEOUT_EN
    checkOutput("hold.timeoutConst", 32'(arbBus.timeout), 32'd1);
`else
    checkOutput("hold.busyConst", 32'(arbBus.busy), 32'd1);
    checkOutput("hold.timeoutConst", 32'(arbBus.timeout), 32'd0);
`endif

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      logic        d;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = 32'd1 << $urandom_range(0, 31);
        2:       r = $urandom() & $urandom() & $urandom();
        default: r = $urandom();
      endcase
      d = ($urandom_range(0, 3) == 0);
      applyStimulus(r, d, "random");
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_32.md
RR_ARBITER_32 -- requirements
Module: rr_arbiter_32

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles a grant is held (used only when RR_ARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req  input  32  request vector; bit i is requester i.
REQ-005 The block SHALL have port done  input  1  release strobe from the current grant holder.
REQ-006 The block SHALL have port grant  output  32  one-hot grant vector, all zero when idle.
REQ-007 The block SHALL have port select  output  5  binary index of the granted requester, which drives the select input of the shared 32:1 mux.
REQ-008 The block SHALL have port busy  output  1  high while any grant is held.
REQ-009 The block SHALL have port timeout  output  1  sticky flag, set on a forced release.

Function
REQ-010 The block SHALL implement two states: IDLE and BUSY.
REQ-011 In IDLE with req nonzero, the block SHALL choose the first set req bit at or above pointer ptr, searching upward with wrap 31->0, and enter BUSY on the next rising edge.
REQ-012 On entry to BUSY, grant SHALL be one-hot at the chosen index, select SHALL equal that index, and busy SHALL be 1, all registered one cycle after the request is sampled.
REQ-013 On each grant, ptr SHALL load (chosen index + 1) mod 32, so that index 31 wraps to 0.
REQ-014 In IDLE with req all zero, the block SHALL hold state, keep grant at 0, keep select at its last value, and leave ptr unchanged.
REQ-015 In BUSY, grant and select SHALL hold until done is sampled high; deassertion of the holder's req SHALL be ignored.
REQ-016 When done is sampled high in BUSY, the block SHALL return to IDLE on that edge: grant 0, busy 0.
REQ-017 The next arbitration after a release SHALL occur no earlier than the following cycle, giving one mandatory idle cycle.
REQ-018 A done signal in IDLE SHALL be ignored.
REQ-019 Simultaneous requests SHALL be resolved only by ptr order; no requester SHALL wait more than 31 grants.
REQ-020 grant SHALL never have more than one bit set, and select SHALL always equal the index of the set grant bit while busy=1.

Reset
REQ-021 While reset is high, the block SHALL force state IDLE, grant 0, select 0, busy 0, timeout 0, ptr 0, and hold count 0, independent of clock.
REQ-022 Assertion of reset during BUSY SHALL release the grant immediately (asynchronously); the first grant after reset deassertion SHALL search from index 0.

Configuration
REQ-023 Macro RR_ARB_TIMEOUT_EN SHALL compile in a hold counter, cleared on grant and incremented each BUSY cycle without done.
REQ-024 With RR_ARB_TIMEOUT_EN defined, a count reaching TIMEOUT without done SHALL force the IDLE transition on that edge, exactly as a done would, and set timeout to 1 until reset.
REQ-025 Without RR_ARB_TIMEOUT_EN, the counter SHALL be absent, grants SHALL be held indefinitely until done, and timeout SHALL be tied to 0.

Verification
REQ-026 Reset released, req=0x00000001 -> one cycle later grant=0x00000001, select=0, busy=1; after a done pulse, grant=0 and busy=0.
REQ-027 req=0xFFFFFFFF held constant, done pulsed each BUSY cycle -> select sequence 0,1,2,...,31,0, with an idle cycle between grants.
REQ-028 With ptr=5, req=0x00000011 (bits 0 and 4) -> wrap search grants select=0 first, then select=4.
REQ-029 Granted requester 3 drops req while BUSY -> grant stays 0x00000008 until done is sampled.
REQ-030 Reset asserted mid-grant at select=17 -> grant=0, busy=0 with no clock edge; next grant with req=0x80020000 gives select=17.
REQ-031 With RR_ARB_TIMEOUT_EN and TIMEOUT=16, no done -> release after 16 BUSY cycles and timeout=1 sticky; without the macro, grant is held for 100 cycles and timeout=0.
